// File: rtl/twos_to_sign_mag.sv
// twos_to_sign_mag: two-stage valid/ready pipeline converting a (MAG_W+1)-bit
// two's complement value into sign + MAG_W-bit magnitude.
// Stage 1 captures the raw input. Stage 2 holds the converted result that
// drives the io_out_* ports.
// The most negative input (-2^MAG_W) saturates to an all-ones magnitude with
// io_out_ovf set.
// Optional feature macro TWOS2SM_OVF_CNT_EN adds io_ovf_count. This is a
// saturating 16-bit count of accepted output beats that had io_out_ovf=1.
module twos_to_sign_mag #(
    parameter int unsigned MAG_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [MAG_W:0]   io_in_twos,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic             io_out_sign,
    output logic [MAG_W-1:0] io_out_mag,
    output logic             io_out_ovf
`ifdef TWOS2SM_OVF_CNT_EN
    ,
    output logic [15:0]      io_ovf_count
`endif
);

    logic             s1_valid;
    logic [MAG_W:0]   s1_data;
    logic             s2_valid;
    logic             s2_sign;
    logic [MAG_W-1:0] s2_mag;
    logic             s2_ovf;

    logic             in_fire;
    logic             move;
    logic             out_fire;

    logic             conv_sign;
    logic [MAG_W-1:0] conv_mag;
    logic             conv_ovf;
    logic [MAG_W-1:0] negated;
    logic             is_min;

    // Handshake: s1 may accept whenever it is empty or will empty on this edge.
    always_comb begin
        io_in_ready = !s1_valid || !s2_valid || io_out_ready;
        in_fire     = io_in_valid && io_in_ready;
        move        = s1_valid && (!s2_valid || io_out_ready);
        out_fire    = s2_valid && io_out_ready;
    end

    // Conversion of the stage-1 value; only the low MAG_W bits of the negation matter.
    always_comb begin
        negated   = ~s1_data[MAG_W-1:0] + {{(MAG_W-1){1'b0}}, 1'b1};
        is_min    = s1_data[MAG_W] && (s1_data[MAG_W-1:0] == '0);
        conv_sign = s1_data[MAG_W];
        conv_ovf  = is_min;
        if (is_min) begin
            conv_mag = '1;
        end else if (s1_data[MAG_W]) begin
            conv_mag = negated;
        end else begin
            conv_mag = s1_data[MAG_W-1:0];
        end
    end

    // Stage 1: capture the raw input beat; it clears when it moves on without a refill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_data  <= io_in_twos;
            end else if (move) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: hold the converted beat until downstream accepts it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_ovf   <= 1'b0;
        end else begin
            if (move) begin
                s2_valid <= 1'b1;
                s2_sign  <= conv_sign;
                s2_mag   <= conv_mag;
                s2_ovf   <= conv_ovf;
            end else if (out_fire) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Output ports mirror stage 2.
    always_comb begin
        io_out_valid = s2_valid;
        io_out_sign  = s2_sign;
        io_out_mag   = s2_mag;
        io_out_ovf   = s2_ovf;
    end

`ifdef TWOS2SM_OVF_CNT_EN
    logic [15:0] ovf_count;

    // Count accepted saturated beats, sticking at the maximum value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_count <= '0;
        end else if (out_fire && s2_ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 16'd1;
        end
    end

    // Expose the counter.
    always_comb begin
        io_ovf_count = ovf_count;
    end
`endif

endmodule

// File: tb/tb_twos_to_sign_mag.sv
// Directed and randomised checks for twos_to_sign_mag with MAG_W=8.
// The counter checks are included when TWOS2SM_OVF_CNT_EN is defined.
module tb_twos_to_sign_mag;

    logic       clock;
    logic       reset;
    logic       io_in_valid;
    logic       io_in_ready;
    logic [8:0] io_in_twos;
    logic       io_out_valid;
    logic       io_out_ready;
    logic       io_out_sign;
    logic [7:0] io_out_mag;
    logic       io_out_ovf;
`ifdef TWOS2SM_OVF_CNT_EN
    logic [15:0] io_ovf_count;
`endif

    int checks = 0;
    int errors = 0;

    twos_to_sign_mag #(.MAG_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_twos   (io_in_twos),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_sign  (io_out_sign),
        .io_out_mag   (io_out_mag),
        .io_out_ovf   (io_out_ovf)
`ifdef TWOS2SM_OVF_CNT_EN
        ,
        .io_ovf_count (io_ovf_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference conversion done with integer arithmetic: {sign, mag, ovf}.
    function automatic logic [9:0] ref_conv(input logic [8:0] x);
        int v;
        int m;
        logic s;
        logic o;
        v = x[8] ? int'(x) - 512 : int'(x);
        s = (v < 0);
        m = s ? -v : v;
        o = (m > 255);
        if (o) m = 255;
        return {s, 8'(m), o};
    endfunction

    // Drive one cycle of inputs at the falling edge and let combinational paths settle.
    task automatic drive(input logic v, input logic [8:0] d, input logic r);
        @(negedge clock);
        io_in_valid  = v;
        io_in_twos   = d;
        io_out_ready = r;
        #1;
    endtask

    task automatic test_reset;
        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_in_twos   = '0;
        io_out_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", io_out_valid); end
        checks++;
        if ({io_out_sign, io_out_mag, io_out_ovf} !== 10'h000) begin
            errors++; $display("FAIL reset_data: got %h expected 000", {io_out_sign, io_out_mag, io_out_ovf});
        end
        checks++;
        if (io_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", io_in_ready); end
`ifdef TWOS2SM_OVF_CNT_EN
        checks++;
        if (io_ovf_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", io_ovf_count); end
`endif
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [8:0] vin [4];
        logic [9:0] vexp [4];
        vin[0] = 9'h1FF; vexp[0] = {1'b1, 8'd1,   1'b0};
        vin[1] = 9'h07F; vexp[1] = {1'b0, 8'd127, 1'b0};
        vin[2] = 9'h000; vexp[2] = {1'b0, 8'd0,   1'b0};
        vin[3] = 9'h181; vexp[3] = {1'b1, 8'd127, 1'b0};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) drive(1'b1, vin[i], 1'b1);
            else       drive(1'b0, 9'h000, 1'b1);
            checks++;
            if (io_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, io_in_ready); end
            if (i < 2 || i == 6) begin
                checks++;
                if (io_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d]: got %b expected 0", i, io_out_valid); end
            end else begin
                checks++;
                if (io_out_valid !== 1'b1 || {io_out_sign, io_out_mag, io_out_ovf} !== vexp[i-2]) begin
                    errors++;
                    $display("FAIL b2b_out[%0d]: got v=%b %h expected v=1 %h", i, io_out_valid,
                             {io_out_sign, io_out_mag, io_out_ovf}, vexp[i-2]);
                end
            end
        end
    endtask

    task automatic test_ovf;
        drive(1'b1, 9'h100, 1'b1);
        drive(1'b0, 9'h000, 1'b1);
        checks++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL ovf_latency: got %b expected 0", io_out_valid); end
        drive(1'b0, 9'h000, 1'b1);
        checks++;
        if (io_out_valid !== 1'b1 || {io_out_sign, io_out_mag, io_out_ovf} !== {1'b1, 8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL ovf_out: got v=%b %h expected v=1 %h", io_out_valid,
                     {io_out_sign, io_out_mag, io_out_ovf}, {1'b1, 8'hFF, 1'b1});
        end
`ifdef TWOS2SM_OVF_CNT_EN
        checks++;
        if (io_ovf_count !== 16'd0) begin errors++; $display("FAIL ovf_count_before: got %h expected 0000", io_ovf_count); end
`endif
        drive(1'b0, 9'h000, 1'b1);
        checks++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", io_out_valid); end
`ifdef TWOS2SM_OVF_CNT_EN
        checks++;
        if (io_ovf_count !== 16'd1) begin errors++; $display("FAIL ovf_count_after: got %h expected 0001", io_ovf_count); end
`endif
    endtask

    task automatic test_backpressure;
        logic [9:0] ea;
        logic [9:0] eb;
        logic [9:0] ec;
        ea = {1'b1, 8'd2,   1'b0};  // 9'h1FE = -2
        eb = {1'b0, 8'd5,   1'b0};  // 9'h005
        ec = {1'b0, 8'd255, 1'b0};  // 9'h0FF
        drive(1'b1, 9'h1FE, 1'b0);
        checks++;
        if (io_in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a: got %b expected 1", io_in_ready); end
        drive(1'b1, 9'h005, 1'b0);
        checks++;
        if (io_in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_b: got %b expected 1", io_in_ready); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 9'h0FF, 1'b0);
            checks++;
            if (io_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready[%0d]: got %b expected 0", i, io_in_ready); end
            checks++;
            if (io_out_valid !== 1'b1 || {io_out_sign, io_out_mag, io_out_ovf} !== ea) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b %h expected v=1 %h", i, io_out_valid,
                         {io_out_sign, io_out_mag, io_out_ovf}, ea);
            end
        end
        drive(1'b1, 9'h0FF, 1'b1);
        checks++;
        if (io_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", io_in_ready); end
        checks++;
        if (io_out_valid !== 1'b1 || {io_out_sign, io_out_mag, io_out_ovf} !== ea) begin
            errors++; $display("FAIL bp_drain_a: got v=%b %h expected v=1 %h", io_out_valid, {io_out_sign, io_out_mag, io_out_ovf}, ea);
        end
        drive(1'b0, 9'h000, 1'b1);
        checks++;
        if (io_out_valid !== 1'b1 || {io_out_sign, io_out_mag, io_out_ovf} !== eb) begin
            errors++; $display("FAIL bp_drain_b: got v=%b %h expected v=1 %h", io_out_valid, {io_out_sign, io_out_mag, io_out_ovf}, eb);
        end
        drive(1'b0, 9'h000, 1'b1);
        checks++;
        if (io_out_valid !== 1'b1 || {io_out_sign, io_out_mag, io_out_ovf} !== ec) begin
            errors++; $display("FAIL bp_drain_c: got v=%b %h expected v=1 %h", io_out_valid, {io_out_sign, io_out_mag, io_out_ovf}, ec);
        end
        drive(1'b0, 9'h000, 1'b1);
        checks++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", io_out_valid); end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 9'h003, 1'b1);
        drive(1'b1, 9'h1FD, 1'b1);
        drive(1'b1, 9'h004, 1'b1);
        checks++;
        if (io_out_valid !== 1'b1 || {io_out_sign, io_out_mag, io_out_ovf} !== {1'b0, 8'd3, 1'b0}) begin
            errors++; $display("FAIL arst_pre: got v=%b %h expected v=1 006", io_out_valid, {io_out_sign, io_out_mag, io_out_ovf});
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", io_out_valid); end
        checks++;
        if ({io_out_sign, io_out_mag, io_out_ovf} !== 10'h000) begin
            errors++; $display("FAIL arst_data: got %h expected 000", {io_out_sign, io_out_mag, io_out_ovf});
        end
        io_in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 9'h1F0, 1'b1);
        drive(1'b0, 9'h000, 1'b1);
        checks++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL arst_latency: got %b expected 0", io_out_valid); end
        drive(1'b0, 9'h000, 1'b1);
        checks++;
        if (io_out_valid !== 1'b1 || {io_out_sign, io_out_mag, io_out_ovf} !== {1'b1, 8'd16, 1'b0}) begin
            errors++; $display("FAIL arst_first: got v=%b %h expected v=1 220", io_out_valid, {io_out_sign, io_out_mag, io_out_ovf});
        end
        drive(1'b0, 9'h000, 1'b1);
        checks++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL arst_no_dup: got %b expected 0", io_out_valid); end
`ifdef TWOS2SM_OVF_CNT_EN
        checks++;
        if (io_ovf_count !== 16'd0) begin errors++; $display("FAIL arst_count: got %h expected 0000", io_ovf_count); end
`endif
    endtask

    task automatic test_random;
        logic [9:0] q[$];
        logic [9:0] cur;
        logic [9:0] hold_val;
        logic       hold_pending;
        int         sent;
        int         got;
        int         cyc;
        int         model_cnt;
        logic       exp_ready;
        sent = 0; got = 0; cyc = 0; model_cnt = 0; hold_pending = 1'b0; hold_val = '0;
        while (got < 3000 && cyc < 40000) begin
            @(negedge clock);
            cur = {io_out_sign, io_out_mag, io_out_ovf};
            if (hold_pending) begin
                checks++;
                if (io_out_valid !== 1'b1 || cur !== hold_val) begin
                    errors++; $display("FAIL rnd_stable: got v=%b %h expected v=1 %h", io_out_valid, cur, hold_val);
                end
            end
            io_out_ready = ($urandom_range(0, 3) != 0);
            io_in_valid  = (sent < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
            io_in_twos   = ($urandom_range(0, 15) == 0) ? 9'h100 : 9'($urandom_range(0, 511));
            #1;
            exp_ready = (q.size() < 2) || io_out_ready;
            checks++;
            if (io_in_ready !== exp_ready) begin
                errors++; $display("FAIL rnd_in_ready: got %b expected %b (occupancy %0d)", io_in_ready, exp_ready, q.size());
            end
            if (q.size() == 0) begin
                checks++;
                if (io_out_valid !== 1'b0) begin errors++; $display("FAIL rnd_spurious: got %b expected 0", io_out_valid); end
            end
            if (io_out_valid && io_out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra_beat: got %h expected none", cur);
                end else begin
                    if (cur !== q[0]) begin errors++; $display("FAIL rnd_data: got %h expected %h", cur, q[0]); end
                    if (q[0][0] && model_cnt < 65535) model_cnt++;
                    void'(q.pop_front());
                end
                got++;
            end
            if (io_in_valid && io_in_ready) begin
                q.push_back(ref_conv(io_in_twos));
                sent++;
            end
            hold_pending = io_out_valid && !io_out_ready;
            hold_val     = cur;
            cyc++;
        end
        checks++;
        if (got != 3000) begin errors++; $display("FAIL rnd_timeout: got %0d beats expected 3000", got); end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL rnd_leftover: got %0d queued expected 0", q.size()); end
`ifdef TWOS2SM_OVF_CNT_EN
        checks++;
        if (io_ovf_count !== 16'(model_cnt)) begin errors++; $display("FAIL rnd_count: got %h expected %h", io_ovf_count, 16'(model_cnt)); end
`endif
        drive(1'b0, 9'h000, 1'b1);
    endtask

`ifdef TWOS2SM_OVF_CNT_EN
    task automatic test_ovf_saturate;
        for (int i = 0; i < 70000; i++) drive(1'b1, 9'h100, 1'b1);
        repeat (3) drive(1'b0, 9'h000, 1'b1);
        checks++;
        if (io_ovf_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_saturate: got %h expected ffff", io_ovf_count); end
        repeat (4) drive(1'b1, 9'h100, 1'b1);
        repeat (3) drive(1'b0, 9'h000, 1'b1);
        checks++;
        if (io_ovf_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_hold: got %h expected ffff", io_ovf_count); end
    endtask
`endif

    initial begin
        test_reset;
        test_back_to_back;
        test_ovf;
        test_backpressure;
        test_async_reset;
        test_random;
`ifdef TWOS2SM_OVF_CNT_EN
        test_ovf_saturate;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
